// File: rtl/sys_irq_pkg.sv
// Shared constants for the interrupt controller: the register word addresses
// and the largest number of sources the 16-bit register file can carry.
package sys_irq_pkg;

   localparam int MAX_SRC = 16;
   localparam int DATA_W  = 16;

   localparam logic [2:0] ADDR_PENDING    = 3'd0;
   localparam logic [2:0] ADDR_ENABLE     = 3'd1;
   localparam logic [2:0] ADDR_RAW        = 3'd2;
   localparam logic [2:0] ADDR_ACTIVE     = 3'd3;
   localparam logic [2:0] ADDR_VECTOR     = 3'd4;
   localparam logic [2:0] ADDR_EDGE_SEL   = 3'd5;
   localparam logic [2:0] ADDR_SW_TRIGGER = 3'd6;
   localparam logic [2:0] ADDR_GLOBAL     = 3'd7;

endpackage

// File: rtl/sys_irq_prio_enc.sv
// Lowest-set-bit priority encoder (bit 0 highest priority).
// Ports:
//   req_i   [WIDTH-1:0]  request vector
//   idx_o   [3:0]        index of lowest set bit, 0 when nothing is set
//   valid_o              at least one request bit is set
module sys_irq_prio_enc #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] req_i,
   output logic [3:0]       idx_o,
   output logic             valid_o
);

   // Scanning downward lets the lowest set index be the last one written.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = 4'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sys_irq_ctrl.sv
// Interrupt controller with an Avalon-MM register slave.
// Per source: level or rising-edge capture into PENDING, enable mask,
// software trigger; aggregated registered irq gated by GLOBAL[0].
// Ports:
//   clk, reset_n           clock, async active-low reset
//   irq_src   [NUM_SRC-1:0] interrupt requests (bit 0 = system timer)
//   address   [2:0]         register word address
//   chipselect, write_n     slave select, active-low write strobe
//   writedata [15:0]        write data
//   readdata  [15:0]        registered read data, 1-cycle latency
//   irq                     registered interrupt to the CPU
module sys_irq_ctrl
   import sys_irq_pkg::*;
#(
   parameter int          NUM_SRC      = 8,
   parameter logic [15:0] EDGE_DEFAULT = 16'h0000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   output logic               irq
);

   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
   logic [NUM_SRC-1:0] src_dly_q;
   logic               global_q, global_d;
   logic               armed_q;
   logic               irq_q, irq_d;
   logic [15:0]        readdata_q, readdata_d;

   logic [NUM_SRC-1:0] wdata, active, rise, edge_set, edge_clr;
   logic               wr_en;
   logic [3:0]         vec_idx;
   logic               vec_valid;

   assign wr_en  = chipselect & ~write_n;
   assign wdata  = writedata[NUM_SRC-1:0];
   assign active = pending_q & enable_q;

   sys_irq_prio_enc #(.WIDTH(NUM_SRC)) u_prio (
      .req_i   (active),
      .idx_o   (vec_idx),
      .valid_o (vec_valid)
   );

   always_comb begin
      enable_d   = enable_q;
      edge_sel_d = edge_sel_q;
      global_d   = global_q;
      if (wr_en && address == ADDR_ENABLE)   enable_d   = wdata;
      if (wr_en && address == ADDR_EDGE_SEL) edge_sel_d = wdata;
      if (wr_en && address == ADDR_GLOBAL)   global_d   = writedata[0];

      // armed_q masks the first clock after reset so a source already high
      // at release is not mistaken for an edge.
      rise     = irq_src & ~src_dly_q & {NUM_SRC{armed_q}};
      edge_set = rise | ((wr_en && address == ADDR_SW_TRIGGER) ? wdata : '0);
      edge_clr = (wr_en && address == ADDR_PENDING) ? wdata : '0;

      // Set beats clear on edge bits; level bits simply track the input,
      // which also discards latched state when a bit is switched to level.
      pending_d = (edge_sel_q & (edge_set | (pending_q & ~edge_clr)))
                | (~edge_sel_q & irq_src);

      irq_d = global_q & (|active);

      unique case (address)
         ADDR_PENDING:    readdata_d = 16'(pending_q);
         ADDR_ENABLE:     readdata_d = 16'(enable_q);
         ADDR_RAW:        readdata_d = 16'(irq_src);
         ADDR_ACTIVE:     readdata_d = 16'(active);
         ADDR_VECTOR:     readdata_d = {vec_valid, 11'b0, vec_idx};
         ADDR_EDGE_SEL:   readdata_d = 16'(edge_sel_q);
         ADDR_SW_TRIGGER: readdata_d = 16'h0000;
         ADDR_GLOBAL:     readdata_d = {15'b0, global_q};
         default:         readdata_d = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q  <= '0;
         enable_q   <= '0;
         edge_sel_q <= EDGE_DEFAULT[NUM_SRC-1:0];
         global_q   <= 1'b0;
         src_dly_q  <= '0;
         armed_q    <= 1'b0;
         irq_q      <= 1'b0;
         readdata_q <= 16'h0000;
      end else begin
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         edge_sel_q <= edge_sel_d;
         global_q   <= global_d;
         src_dly_q  <= irq_src;
         armed_q    <= 1'b1;
         irq_q      <= irq_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// Scoreboard bench for sys_irq_ctrl: the driver applies one bus/irq_src
// pattern per cycle, predicts readdata and irq from a per-source behavioural
// model, and queues the prediction; the monitor compares after each edge.
module tb_sys_irq_ctrl;

   localparam int          N        = 8;
   localparam logic [15:0] EDGE_DEF = 16'h0008;
   localparam logic [15:0] MASK     = 16'((1 << N) - 1);

   logic          clk = 1'b0;
   logic          reset_n;
   logic [N-1:0]  irq_src;
   logic [2:0]    address;
   logic          chipselect, write_n;
   logic [15:0]   writedata;
   logic [15:0]   readdata;
   logic          irq;

   always #5 clk = ~clk;

   sys_irq_ctrl #(.NUM_SRC(N), .EDGE_DEFAULT(EDGE_DEF)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .irq_src    (irq_src),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   typedef struct packed {
      logic [15:0] rd;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // reference model state
   logic [15:0] m_pend, m_en, m_edge, m_prev;
   logic        m_glob, m_armed;

   function automatic void m_reset();
      m_pend  = 16'h0;
      m_en    = 16'h0;
      m_edge  = EDGE_DEF & MASK;
      m_glob  = 1'b0;
      m_prev  = 16'h0;
      m_armed = 1'b0;
   endfunction

   function automatic logic [15:0] m_read(input logic [2:0] a, input logic [15:0] src);
      logic [15:0] act;
      logic [15:0] vec;
      act = m_pend & m_en;
      vec = 16'h0;
      for (int i = 0; i < N; i++) begin
         if (act[i] && vec == 16'h0) vec = 16'h8000 | 16'(i);
      end
      case (a)
         3'd0:    return m_pend;
         3'd1:    return m_en;
         3'd2:    return src & MASK;
         3'd3:    return act;
         3'd4:    return vec;
         3'd5:    return m_edge;
         3'd7:    return {15'h0, m_glob};
         default: return 16'h0;
      endcase
   endfunction

   function automatic void m_step(input logic [15:0] src, input logic [2:0] a,
                                  input logic we, input logic [15:0] wd);
      logic [15:0] np;
      np = 16'h0;
      for (int i = 0; i < N; i++) begin
         if (!m_edge[i]) begin
            np[i] = src[i];
         end else if ((m_armed && src[i] && !m_prev[i]) || (we && a == 3'd6 && wd[i])) begin
            np[i] = 1'b1;
         end else if (we && a == 3'd0 && wd[i]) begin
            np[i] = 1'b0;
         end else begin
            np[i] = m_pend[i];
         end
      end
      m_pend  = np;
      m_prev  = src & MASK;
      m_armed = 1'b1;
      if (we && a == 3'd1) m_en   = wd & MASK;
      if (we && a == 3'd5) m_edge = wd & MASK;
      if (we && a == 3'd7) m_glob = wd[0];
   endfunction

   task automatic cycle(input logic [N-1:0] src, input logic [2:0] a,
                        input logic cs, input logic wr, input logic [15:0] wd);
      exp_t e;
      irq_src    = src;
      address    = a;
      chipselect = cs;
      write_n    = ~wr;
      writedata  = wd;
      e.rd  = m_read(a, 16'(src));
      e.irq = m_glob & (|(m_pend & m_en));
      exp_q.push_back(e);
      m_step(16'(src), a, cs && wr, wd);
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [N-1:0] src, input logic [2:0] a, input logic [15:0] wd);
      cycle(src, a, 1'b1, 1'b1, wd);
   endtask

   task automatic rd(input logic [N-1:0] src, input logic [2:0] a);
      cycle(src, a, 1'b1, 1'b0, 16'h0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (readdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_readdata actual=%h expected=0000", readdata);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq actual=%b expected=0", irq);
      end
      #1;
      reset_n = 1'b1;
   endtask

   // monitor: readdata and irq are presented every cycle
   always begin
      @(posedge clk);
      #1;
      if (reset_n && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (readdata !== e.rd) begin
            errors++;
            $display("FAIL readdata t=%0t actual=%h expected=%h", $time, readdata, e.rd);
         end
         checks++;
         if (irq !== e.irq) begin
            errors++;
            $display("FAIL irq t=%0t actual=%b expected=%b", $time, irq, e.irq);
         end
      end
   end

   initial begin
      irq_src    = '0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 16'h0;
      do_reset();

      // level source 0 with enable and global
      wr(8'h00, 3'd1, 16'h0001);
      wr(8'h00, 3'd7, 16'h0001);
      rd(8'h01, 3'd0);
      rd(8'h01, 3'd4);
      rd(8'h01, 3'd4);
      rd(8'h00, 3'd0);
      rd(8'h00, 3'd4);
      rd(8'h00, 3'd0);

      // edge source 2: capture, hold, W1C
      wr(8'h00, 3'd5, 16'h0004);
      wr(8'h00, 3'd1, 16'h0004);
      rd(8'h04, 3'd0);
      rd(8'h00, 3'd0);
      rd(8'h00, 3'd0);
      rd(8'h00, 3'd3);
      wr(8'h00, 3'd0, 16'h0004);
      rd(8'h00, 3'd0);
      rd(8'h00, 3'd0);

      // edge and W1C in the same cycle: set wins
      wr(8'h04, 3'd0, 16'h0004);
      rd(8'h04, 3'd0);
      wr(8'h00, 3'd0, 16'h0004);
      rd(8'h00, 3'd0);

      // priority vector
      wr(8'h00, 3'd5, 16'h0000);
      wr(8'h22, 3'd1, 16'h0022);
      rd(8'h22, 3'd4);
      rd(8'h22, 3'd4);
      wr(8'h22, 3'd1, 16'h0020);
      rd(8'h22, 3'd4);
      rd(8'h22, 3'd4);

      // global off, sw trigger on a level source, bits above N
      wr(8'h22, 3'd7, 16'h0000);
      rd(8'h22, 3'd3);
      wr(8'h22, 3'd6, 16'h0001);
      rd(8'h22, 3'd0);
      wr(8'h22, 3'd1, 16'hFFFF);
      rd(8'h22, 3'd1);
      wr(8'h22, 3'd2, 16'hFFFF);
      wr(8'h22, 3'd4, 16'hFFFF);
      rd(8'h22, 3'd7);

      // sw trigger on an edge source, then switch it to level
      wr(8'h00, 3'd5, 16'h0080);
      wr(8'h00, 3'd6, 16'h0080);
      rd(8'h00, 3'd0);
      wr(8'h00, 3'd5, 16'h0000);
      rd(8'h00, 3'd0);
      rd(8'h00, 3'd0);

      // source 3 high across reset release (edge by default)
      irq_src = 8'h08;
      do_reset();
      rd(8'h08, 3'd0);
      rd(8'h08, 3'd0);
      rd(8'h08, 3'd6);
      rd(8'h08, 3'd5);
      rd(8'h00, 3'd0);

      // randomized traffic with one mid-run reset
      for (int n = 0; n < 600; n++) begin
         logic [N-1:0] s;
         logic [2:0]   a;
         logic         c, w;
         logic [15:0]  d;
         if (n == 300) do_reset();
         s = N'($urandom);
         a = 3'($urandom_range(0, 7));
         c = ($urandom_range(0, 3) != 0);
         w = ($urandom_range(0, 1) == 1);
         d = 16'($urandom);
         cycle(s, a, c, w, d);
      end

      chipselect = 1'b0;
      write_n    = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sys_irq_ctrl.md
SYS_IRQ_CTRL -- requirements
Module: sys_irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources (legal 1..16).
REQ-002 Parameter EDGE_DEFAULT, default 16'h0000, reset value of EDGE_SEL (1 = rising-edge, 0 = level).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 irq_src  input  NUM_SRC  interrupt requests, synchronous to clk; bit 0 driven by the system timer irq.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  16  write data.
REQ-010 readdata  output  16  registered read data.
REQ-011 irq  output  1  aggregated interrupt to CPU, registered.

Function
REQ-012 Register map: 0 PENDING (R, W1C), 1 ENABLE (RW), 2 RAW (R, irq_src), 3 ACTIVE (R, PENDING & ENABLE), 4 VECTOR (R), 5 EDGE_SEL (RW), 6 SW_TRIGGER (W), 7 GLOBAL (RW, bit 0 = global enable).
REQ-013 Write strobe per register = chipselect && !write_n && address match; writes take effect on the next clock edge.
REQ-014 readdata updates every cycle from the address mux, independent of chipselect; read latency exactly 1 cycle.
REQ-015 Bits at or above NUM_SRC read 0 and ignore writes; reserved bits of VECTOR/GLOBAL read 0; writes to read-only addresses 2, 3, 4 have no effect.
REQ-016 Level source (EDGE_SEL[i]=0): PENDING[i] equals registered irq_src[i], one cycle after the input; W1C has no effect.
REQ-017 Edge source (EDGE_SEL[i]=1): PENDING[i] sets on irq_src[i] & ~irq_src_d[i] (irq_src_d = one-cycle delayed copy); holds until W1C.
REQ-018 Simultaneous edge set and W1C on the same bit, same cycle: set wins, PENDING stays 1.
REQ-019 SW_TRIGGER write sets PENDING[i] for each written 1 where EDGE_SEL[i]=1; ignored for level sources.
REQ-020 Changing EDGE_SEL[i] 1->0 discards latched edge state; PENDING[i] follows level rule from the next cycle.
REQ-021 VECTOR: bit 15 = |ACTIVE; bits[3:0] = lowest index set in ACTIVE (fixed priority, source 0 highest); bits[3:0] = 0 when bit 15 = 0; read has no side effect.
REQ-022 irq <= GLOBAL[0] & |(PENDING & ENABLE), registered; asserts 1 cycle after PENDING/ENABLE/GLOBAL condition holds, deasserts 1 cycle after it clears.
REQ-023 Masked (ENABLE=0) sources still latch PENDING and appear in RAW/PENDING reads.

Reset
REQ-024 On reset_n low: PENDING=0, ENABLE=0, EDGE_SEL=EDGE_DEFAULT, GLOBAL=0, irq_src_d=0, readdata=0, irq=0.
REQ-025 Reset mid-operation discards all latched edges; a source high across reset release is not seen as an edge (irq_src_d loads irq_src on the first clock after release).

Structure
REQ-026 Register address constants (PENDING..GLOBAL) and NUM_SRC upper bound in shared package sys_irq_pkg.
REQ-027 One sub-module, sys_irq_prio_enc: combinational NUM_SRC-wide lowest-set-bit encoder with valid flag, used for VECTOR.

Verification
REQ-028 Reset, write ENABLE=16'h0001, GLOBAL=1, pulse irq_src[0] high (level) -> irq=1 one cycle after PENDING[0], VECTOR reads 16'h8000; drop irq_src[0] -> irq=0 within 2 cycles.
REQ-029 EDGE_SEL=16'h0004, ENABLE=16'h0004, GLOBAL=1, 1-cycle pulse on irq_src[2] -> PENDING=16'h0004 held; write PENDING 16'h0004 -> PENDING=0, irq=0 next cycle.
REQ-030 Edge on irq_src[2] same cycle as W1C of bit 2 -> PENDING[2] remains 1.
REQ-031 Sources 1 and 5 active, ENABLE=16'h0022 -> VECTOR=16'h8001; clear ENABLE[1] -> VECTOR=16'h8005.
REQ-032 GLOBAL=0 with active source -> irq=0, ACTIVE nonzero; SW_TRIGGER=16'h0001 with EDGE_SEL[0]=0 -> PENDING unchanged.
REQ-033 Hold irq_src[3] high (EDGE_SEL[3]=1) across reset release -> PENDING[3] stays 0; read of address 6 returns 0 one cycle after address applied.
